// File: rtl/modport_router.sv
// Per-input flit FIFO; a push and a pop may share a cycle even when full.
// Latency: a pushed flit is at the head right after its push edge (no bypass).
// Backpressure: none upstream; a push into a full FIFO without a pop is dropped.
module modport_router_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] dat_i,
    input  logic         pop_i,
    output logic [W-1:0] dat_o,
    output logic         empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full, do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full | do_pop);
    assign dat_o   = mem_q[rd_q];

    // DEPTH is a power of two, so the pointers wrap by overflow.
    always_comb begin
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= dat_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// Five-port XY-routed mesh router: single-flit packets, per-input FIFO, round-robin per output.
// Latency: flit pushed at edge k leaves at edge k+1 when uncontended and credited.
// Backpressure: per-output credit counters; a zero-credit output leaves flits queued at their input.
module modport_router #(
    parameter int X_COORD = 1,
    parameter int Y_COORD = 1,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] north_i,
    input  logic [15:0] south_i,
    input  logic [15:0] east_i,
    input  logic [15:0] west_i,
    input  logic [15:0] local_i,
    input  logic        valid_n_i,
    input  logic        valid_s_i,
    input  logic        valid_e_i,
    input  logic        valid_w_i,
    input  logic        valid_l_i,
    input  logic        n_incr_i,
    input  logic        s_incr_i,
    input  logic        e_incr_i,
    input  logic        w_incr_i,
    input  logic        l_incr_i,
    output logic [15:0] north_o,
    output logic [15:0] south_o,
    output logic [15:0] east_o,
    output logic [15:0] west_o,
    output logic [15:0] local_o,
    output logic        valid_n_o,
    output logic        valid_s_o,
    output logic        valid_e_o,
    output logic        valid_w_o,
    output logic        valid_l_o,
    output logic        n_incr_o,
    output logic        s_incr_o,
    output logic        e_incr_o,
    output logic        w_incr_o,
    output logic        l_incr_o
);
    typedef struct packed {
        logic [3:0] dst_x;
        logic [3:0] dst_y;
        logic [7:0] payload;
    } flit_t;

    localparam int NP = 5;
    localparam int P_N = 0, P_S = 1, P_E = 2, P_W = 3, P_L = 4;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);
    localparam logic [3:0]    XC = 4'(X_COORD);
    localparam logic [3:0]    YC = 4'(Y_COORD);

    flit_t          in_dat [NP];
    flit_t          head   [NP];
    logic [NP-1:0]  in_vld, cred_in, empty, pop;
    logic [2:0]     dest   [NP];
    logic [NP-1:0]  req    [NP];
    logic [NP-1:0]  gnt    [NP];
    logic [NP-1:0]  send;

    flit_t          out_dat_q [NP], out_dat_d [NP];
    logic [NP-1:0]  out_vld_q, out_vld_d, incr_q, incr_d;
    logic [CW-1:0]  cred_q [NP], cred_d [NP];
    logic [2:0]     ptr_q  [NP], ptr_d  [NP];

    assign in_dat[P_N] = north_i;
    assign in_dat[P_S] = south_i;
    assign in_dat[P_E] = east_i;
    assign in_dat[P_W] = west_i;
    assign in_dat[P_L] = local_i;
    assign in_vld  = {valid_l_i, valid_w_i, valid_e_i, valid_s_i, valid_n_i};
    assign cred_in = {l_incr_i, w_incr_i, e_incr_i, s_incr_i, n_incr_i};

    for (genvar gi = 0; gi < NP; gi++) begin : g_in
        modport_router_fifo #(.W($bits(flit_t)), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (in_vld[gi]),
            .dat_i   (in_dat[gi]),
            .pop_i   (pop[gi]),
            .dat_o   (head[gi]),
            .empty_o (empty[gi])
        );
    end

    function automatic logic [2:0] xy_route(input logic [3:0] dx, input logic [3:0] dy);
        logic [2:0] r;
        if (dx > XC)      r = 3'(P_E);
        else if (dx < XC) r = 3'(P_W);
        else if (dy > YC) r = 3'(P_N);
        else if (dy < YC) r = 3'(P_S);
        else              r = 3'(P_L);
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            dest[i] = xy_route(head[i].dst_x, head[i].dst_y);
        end
        for (int o = 0; o < NP; o++) begin
            for (int i = 0; i < NP; i++) begin
                req[o][i] = ~empty[i] & (dest[i] == 3'(o));
            end
        end
    end

    // ptr_q holds the first input to search; it moves past the winner only on a grant.
    always_comb begin
        logic       found;
        logic [3:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int o = 0; o < NP; o++) begin
            gnt[o]   = '0;
            ptr_d[o] = ptr_q[o];
            found    = 1'b0;
            if (cred_q[o] != '0) begin
                for (int k = 0; k < NP; k++) begin
                    idx = {1'b0, ptr_q[o]} + 4'(k);
                    if (idx >= 4'(NP)) idx = idx - 4'(NP);
                    if (!found && req[o][idx[2:0]]) begin
                        found              = 1'b1;
                        gnt[o][idx[2:0]]   = 1'b1;
                        ptr_d[o]           = (idx[2:0] == 3'(NP - 1)) ? 3'd0 : idx[2:0] + 3'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int o = 0; o < NP; o++) begin
            pop     = pop | gnt[o];
            send[o] = |gnt[o];
        end
    end

    always_comb begin
        out_vld_d = send;
        incr_d    = pop;
        for (int o = 0; o < NP; o++) begin
            out_dat_d[o] = out_dat_q[o];
            for (int i = 0; i < NP; i++) begin
                if (gnt[o][i]) out_dat_d[o] = head[i];
            end
            // A return and a send in the same cycle cancel; a send implies credit > 0.
            cred_d[o] = cred_q[o];
            case ({send[o], cred_in[o]})
                2'b10:   cred_d[o] = cred_q[o] - CW'(1);
                2'b01:   cred_d[o] = (cred_q[o] == CRED_MAX) ? CRED_MAX : cred_q[o] + CW'(1);
                default: cred_d[o] = cred_q[o];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q <= '0;
            incr_q    <= '0;
            for (int o = 0; o < NP; o++) begin
                out_dat_q[o] <= '0;
                cred_q[o]    <= CRED_MAX;
                ptr_q[o]     <= '0;
            end
        end else begin
            out_vld_q <= out_vld_d;
            incr_q    <= incr_d;
            for (int o = 0; o < NP; o++) begin
                out_dat_q[o] <= out_dat_d[o];
                cred_q[o]    <= cred_d[o];
                ptr_q[o]     <= ptr_d[o];
            end
        end
    end

    assign north_o   = out_dat_q[P_N];
    assign south_o   = out_dat_q[P_S];
    assign east_o    = out_dat_q[P_E];
    assign west_o    = out_dat_q[P_W];
    assign local_o   = out_dat_q[P_L];
    assign valid_n_o = out_vld_q[P_N];
    assign valid_s_o = out_vld_q[P_S];
    assign valid_e_o = out_vld_q[P_E];
    assign valid_w_o = out_vld_q[P_W];
    assign valid_l_o = out_vld_q[P_L];
    assign n_incr_o  = incr_q[P_N];
    assign s_incr_o  = incr_q[P_S];
    assign e_incr_o  = incr_q[P_E];
    assign w_incr_o  = incr_q[P_W];
    assign l_incr_o  = incr_q[P_L];
endmodule

// File: tb/tb_modport_router.sv
// Directed bench for modport_router at node (1,1), DEPTH 4; ports indexed N=0 S=1 E=2 W=3 L=4.
// Expected flits/credit returns carry the cycle they must appear in; a negedge monitor pops and compares.
module tb_modport_router;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] fin  [5];
    logic [15:0] fout [5];
    logic [4:0]  vin = '0, cin = '0;
    logic [4:0]  vout, iout;
    int          cyc = 0;
    int          n_chk = 0, n_pass = 0;

    typedef struct {
        logic [15:0] dat;
        int          cyc;
    } exp_t;

    exp_t fq [5][$];
    int   iq [5][$];

    initial for (int i = 0; i < 5; i++) fin[i] = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    modport_router #(.X_COORD(1), .Y_COORD(1), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .north_i(fin[0]), .south_i(fin[1]), .east_i(fin[2]), .west_i(fin[3]), .local_i(fin[4]),
        .valid_n_i(vin[0]), .valid_s_i(vin[1]), .valid_e_i(vin[2]), .valid_w_i(vin[3]), .valid_l_i(vin[4]),
        .n_incr_i(cin[0]), .s_incr_i(cin[1]), .e_incr_i(cin[2]), .w_incr_i(cin[3]), .l_incr_i(cin[4]),
        .north_o(fout[0]), .south_o(fout[1]), .east_o(fout[2]), .west_o(fout[3]), .local_o(fout[4]),
        .valid_n_o(vout[0]), .valid_s_o(vout[1]), .valid_e_o(vout[2]), .valid_w_o(vout[3]), .valid_l_o(vout[4]),
        .n_incr_o(iout[0]), .s_incr_o(iout[1]), .e_incr_o(iout[2]), .w_incr_o(iout[3]), .l_incr_o(iout[4])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    endtask

    // Flit dat must leave output o in cycle c, with a credit return on input i in the same cycle.
    task automatic expect_flit(input int o, input int i, input logic [15:0] dat, input int c);
        exp_t e;
        e.dat = dat;
        e.cyc = c;
        fq[o].push_back(e);
        iq[i].push_back(c);
    endtask

    task automatic put(input int i, input logic [15:0] f);
        fin[i] = f;
        vin[i] = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        vin = '0;
        cin = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vin = '0;
        cin = '0;
        #1;
        check("rst_valid", 32'(vout), 32'h0);
        check("rst_incr", 32'(iout), 32'h0);
        check("rst_data", 32'(fout[0] | fout[1] | fout[2] | fout[3] | fout[4]), 32'h0);
        for (int o = 0; o < 5; o++) begin
            fq[o].delete();
            iq[o].delete();
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   c;
        if (!rst) begin
            for (int o = 0; o < 5; o++) begin
                if (vout[o]) begin
                    if (fq[o].size() == 0) begin
                        check($sformatf("unexpected_valid_out%0d", o), 32'(vout[o]), 32'h0);
                    end else begin
                        e = fq[o].pop_front();
                        check($sformatf("flit_out%0d {data,cycle}", o),
                              {fout[o], 16'(cyc)}, {e.dat, 16'(e.cyc)});
                    end
                end else if (fq[o].size() > 0 && fq[o][0].cyc <= cyc) begin
                    e = fq[o].pop_front();
                    check($sformatf("missing_valid_out%0d_flit_%h", o, e.dat), 32'(vout[o]), 32'h1);
                end
                if (iout[o]) begin
                    if (iq[o].size() == 0) begin
                        check($sformatf("unexpected_incr_in%0d", o), 32'(iout[o]), 32'h0);
                    end else begin
                        c = iq[o].pop_front();
                        check($sformatf("incr_in%0d_cycle", o), 32'(cyc), 32'(c));
                    end
                end else if (iq[o].size() > 0 && iq[o][0] <= cyc) begin
                    c = iq[o].pop_front();
                    check($sformatf("missing_incr_in%0d", o), 32'(iout[o]), 32'h1);
                end
            end
        end
    end

    initial begin
        int c;
        #2;
        do_reset();

        // Asynchronous reset while a flit is on the output and another sits buffered.
        put(4, 16'h11A0); expect_flit(4, 4, 16'h11A0, cyc + 2); step();
        put(4, 16'h11A1); step();
        @(negedge clk);
        #1;
        do_reset();
        repeat (3) step();

        // Local delivery, then idle output holds its data.
        put(4, 16'h11A5); expect_flit(4, 4, 16'h11A5, cyc + 2); step();
        step(); step();
        @(negedge clk);
        check("idle_hold {valid,data}", {15'h0, vout[4], fout[4]}, {15'h0, 1'b0, 16'h11A5});
        step();

        // XY routing from local, plus an east-to-east U-turn.
        put(4, 16'h3042); expect_flit(2, 4, 16'h3042, cyc + 2); step();
        put(4, 16'h0243); expect_flit(3, 4, 16'h0243, cyc + 2); step();
        put(4, 16'h1344); expect_flit(0, 4, 16'h1344, cyc + 2); step();
        put(4, 16'h1045); expect_flit(1, 4, 16'h1045, cyc + 2); step();
        put(2, 16'h3155); expect_flit(2, 2, 16'h3155, cyc + 2); step();
        repeat (4) step();

        // Contention on local: N before W from reset, then alternation.
        do_reset();
        put(0, 16'h11B1); put(3, 16'h11B2);
        expect_flit(4, 0, 16'h11B1, cyc + 2);
        expect_flit(4, 3, 16'h11B2, cyc + 3);
        step();
        repeat (3) step();
        cin[4] = 1'b1; step();
        cin[4] = 1'b1; step();
        c = cyc;
        put(0, 16'h11C1); put(3, 16'h11C3);
        expect_flit(4, 0, 16'h11C1, c + 2);
        expect_flit(4, 3, 16'h11C3, c + 3);
        step();
        put(0, 16'h11C2); put(3, 16'h11C4);
        expect_flit(4, 0, 16'h11C2, c + 4);
        expect_flit(4, 3, 16'h11C4, c + 5);
        step();
        repeat (5) step();

        // Credit stall on east: four go, the fifth waits for one returned credit.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            put(4, 16'h21D0 + 16'(k));
            if (k < 4) expect_flit(2, 4, 16'h21D0 + 16'(k), cyc + 2);
            step();
        end
        repeat (3) step();
        cin[2] = 1'b1; expect_flit(2, 4, 16'h21D4, cyc + 2); step();
        repeat (3) step();

        // Six returns saturate at 4; return coinciding with a send keeps 4.
        for (int k = 0; k < 6; k++) begin
            cin[2] = 1'b1;
            step();
        end
        put(4, 16'h21E0); expect_flit(2, 4, 16'h21E0, cyc + 2); step();
        cin[2] = 1'b1; step();
        for (int k = 1; k < 6; k++) begin
            put(4, 16'h21E0 + 16'(k));
            if (k < 5) expect_flit(2, 4, 16'h21E0 + 16'(k), cyc + 2);
            step();
        end
        repeat (3) step();
        cin[2] = 1'b1; expect_flit(2, 4, 16'h21E5, cyc + 2); step();
        repeat (3) step();

        // Overfill the stalled local FIFO: the fifth push is dropped.
        for (int k = 0; k < 5; k++) begin
            put(4, 16'h21F0 + 16'(k));
            step();
        end
        for (int k = 0; k < 5; k++) begin
            cin[2] = 1'b1;
            if (k < 4) expect_flit(2, 4, 16'h21F0 + 16'(k), cyc + 2);
            step();
        end
        repeat (5) step();

        @(negedge clk);
        #1;
        for (int o = 0; o < 5; o++) begin
            check($sformatf("drain_flits_out%0d", o), 32'(fq[o].size()), 32'h0);
            check($sformatf("drain_incr_in%0d", o), 32'(iq[o].size()), 32'h0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
